// File: rtl/sonic_vc_tx_arbiter_if.sv
// Avalon-ST bundle between the virtual-channel sources, the TX arbiter and the
// downstream timing adapter: NUM_CH input lanes plus one merged output lane.
interface sonic_vc_tx_arbiter_if #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 128,
  parameter int EMPTY_W = 2
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]         in_valid;
  logic [NUM_CH-1:0]         in_ready;
  logic [NUM_CH*DATA_W-1:0]  in_data;
  logic [NUM_CH-1:0]         in_error;
  logic [NUM_CH-1:0]         in_startofpacket;
  logic [NUM_CH-1:0]         in_endofpacket;
  logic [NUM_CH*EMPTY_W-1:0] in_empty;

  logic                      out_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_error;
  logic                      out_startofpacket;
  logic                      out_endofpacket;
  logic [EMPTY_W-1:0]        out_empty;
  logic [CH_W-1:0]           out_channel;

  // Sources and sink side: drives the channel lanes, consumes the merged lane.
  modport master (
    output in_valid, in_data, in_error, in_startofpacket, in_endofpacket, in_empty,
    input  in_ready,
    output out_ready,
    input  out_valid, out_data, out_error, out_startofpacket, out_endofpacket,
    input  out_empty, out_channel
  );

  // Arbiter side.
  modport slave (
    input  in_valid, in_data, in_error, in_startofpacket, in_endofpacket, in_empty,
    output in_ready,
    input  out_ready,
    output out_valid, out_data, out_error, out_startofpacket, out_endofpacket,
    output out_empty, out_channel
  );
endinterface

// File: rtl/sonic_vc_tx_arbiter.sv
// Packet-aware round-robin merge of NUM_CH Avalon-ST virtual channels into one
// registered stream. Per-channel packet counters exist only with SONIC_VC_TX_ARB_PKT_COUNT_EN.
module sonic_vc_tx_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 128,
  parameter int EMPTY_W = 2,
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       chan_enable,
  sonic_vc_tx_arbiter_if.slave    st,
  output logic                    busy,
  output logic [NUM_CH*CNT_W-1:0] pkt_count
);
  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic {IDLE, XFER} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [CH_W-1:0]     last_grant_q, last_grant_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_error_q, out_error_d;
  logic                out_sop_q, out_sop_d;
  logic                out_eop_q, out_eop_d;
  logic [EMPTY_W-1:0]  out_empty_q, out_empty_d;
  logic [CH_W-1:0]     out_channel_q, out_channel_d;

  logic [DATA_W-1:0]   data_arr  [NUM_CH];
  logic [EMPTY_W-1:0]  empty_arr [NUM_CH];
  logic [NUM_CH-1:0]   req;
  logic [CH_W-1:0]     pick;
  logic                pick_vld;
  logic                adv;
  logic                accept;
  logic                grant_eop;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    assign data_arr[gi]    = st.in_data[gi*DATA_W +: DATA_W];
    assign empty_arr[gi]   = st.in_empty[gi*EMPTY_W +: EMPTY_W];
    assign st.in_ready[gi] = (state_q == XFER) && (grant_q == CH_W'(gi)) && adv;
  end

  assign adv       = !out_valid_q || st.out_ready;
  assign accept    = (state_q == XFER) && st.in_valid[grant_q] && adv;
  assign grant_eop = st.in_endofpacket[grant_q];
  assign req       = st.in_valid & chan_enable & st.in_startofpacket;

  // Scan offsets from the far end so the channel nearest last_grant+1 is written last.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (req[(int'(last_grant_q) + i) % NUM_CH]) begin
        pick     = CH_W'((int'(last_grant_q) + i) % NUM_CH);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_error_d   = out_error_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    out_empty_d   = out_empty_q;
    out_channel_d = out_channel_q;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          state_d = XFER;
        end
      end
      XFER: begin
        if (accept && grant_eop) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      out_valid_d = accept;
      if (accept) begin
        out_data_d    = data_arr[grant_q];
        out_error_d   = st.in_error[grant_q];
        out_sop_d     = st.in_startofpacket[grant_q];
        out_eop_d     = grant_eop;
        out_empty_d   = empty_arr[grant_q];
        out_channel_d = grant_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_grant_q  <= CH_W'(NUM_CH - 1);
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_error_q   <= 1'b0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_empty_q   <= '0;
      out_channel_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_error_q   <= out_error_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      out_empty_q   <= out_empty_d;
      out_channel_q <= out_channel_d;
    end
  end

  assign st.out_valid         = out_valid_q;
  assign st.out_data          = out_data_q;
  assign st.out_error         = out_error_q;
  assign st.out_startofpacket = out_sop_q;
  assign st.out_endofpacket   = out_eop_q;
  assign st.out_empty         = out_empty_q;
  assign st.out_channel       = out_channel_q;
  assign busy                 = (state_q == XFER);

`ifdef SONIC_VC_TX_ARB_PKT_COUNT_EN
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (accept && grant_eop && (grant_q == CH_W'(gi))) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign pkt_count[gi*CNT_W +: CNT_W] = cnt_q;
  end
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_sonic_vc_tx_arbiter.sv
// Directed bench for sonic_vc_tx_arbiter: a cycle table for the basic two-packet
// merge, plus queued-source sequences for rotation, backpressure, enables and reset.
module tb_sonic_vc_tx_arbiter;
  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 128;
  localparam int EMPTY_W = 2;
  localparam int CNT_W   = 4;

  logic                    clk;
  logic                    reset_n;
  logic [NUM_CH-1:0]       chan_enable;
  logic                    busy;
  logic [NUM_CH*CNT_W-1:0] pkt_count;

  sonic_vc_tx_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) bus ();

  sonic_vc_tx_arbiter #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chan_enable(chan_enable),
    .st         (bus),
    .busy       (busy),
    .pkt_count  (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] tag;
    logic       sop;
    logic       eop;
  } beat_t;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic               err;
    logic [EMPTY_W-1:0] emp;
    logic [1:0]         ch;
  } obs_t;

  typedef struct packed {
    logic [3:0]  vld;
    logic [3:0]  sop;
    logic [3:0]  eop;
    logic [15:0] beat;
    logic [3:0]  x_rdy;
    logic        x_busy;
    logic        x_ov;
    logic [7:0]  x_tag;
    logic        x_sop;
    logic        x_eop;
  } vec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t src_q [NUM_CH][$];
  beat_t exp_q [$];
  obs_t  obs_q [$];
  vec_t  tbl   [10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [3:0] vld, input logic [3:0] sop,
                               input logic [3:0] eop, input logic [15:0] beat,
                               input logic [3:0] rdy, input logic bsy, input logic ov,
                               input logic [7:0] tag, input logic s, input logic e);
    vec_t v;
    v = '{vld: vld, sop: sop, eop: eop, beat: beat, x_rdy: rdy, x_busy: bsy,
          x_ov: ov, x_tag: tag, x_sop: s, x_eop: e};
    return v;
  endfunction

  task automatic drive_ch(input int c, input logic v, input logic [7:0] t,
                          input logic s, input logic e);
    bus.in_valid[c]                    = v;
    bus.in_data[c*DATA_W +: DATA_W]    = v ? {16{t}} : '0;
    bus.in_error[c]                    = v & t[0];
    bus.in_empty[c*EMPTY_W +: EMPTY_W] = v ? t[1:0] : 2'b00;
    bus.in_startofpacket[c]            = v & s;
    bus.in_endofpacket[c]              = v & e;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick(input logic rdy);
    logic [NUM_CH-1:0] acc;
    obs_t o;
    bus.out_ready = rdy;
    for (int c = 0; c < NUM_CH; c++) begin
      if (src_q[c].size() > 0) drive_ch(c, 1'b1, src_q[c][0].tag, src_q[c][0].sop, src_q[c][0].eop);
      else                     drive_ch(c, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    #1;
    check("in_ready_onehot", 128'($countones(bus.in_ready) <= 1), 128'(1));
    acc = bus.in_valid & bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      o.data = bus.out_data;
      o.sop  = bus.out_startofpacket;
      o.eop  = bus.out_endofpacket;
      o.err  = bus.out_error;
      o.emp  = bus.out_empty;
      o.ch   = bus.out_channel;
      obs_q.push_back(o);
    end
    @(posedge clk);
    for (int c = 0; c < NUM_CH; c++) if (acc[c]) void'(src_q[c].pop_front());
    @(negedge clk);
  endtask

  task automatic add_pkt(input int c, input int n, input int base, input bit to_exp);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.tag = {4'(c), 4'(base + k)};
      b.sop = (k == 0);
      b.eop = (k == n - 1);
      if (to_exp) exp_q.push_back(b);
      else        src_q[c].push_back(b);
    end
  endtask

  function automatic bit any_src();
    for (int c = 0; c < NUM_CH; c++) if (src_q[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while ((any_src() || bus.out_valid) && n < 200) begin
      tick(1'b1);
      n++;
    end
    check({name, "_drain_timeout"}, 128'(n < 200), 128'(1));
  endtask

  task automatic compare_obs(input string name);
    int n;
    check({name, "_beat_count"}, 128'(obs_q.size()), 128'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_b%0d_data", name, i), obs_q[i].data, {16{exp_q[i].tag}});
      check($sformatf("%s_b%0d_ch", name, i), 128'(obs_q[i].ch), 128'(exp_q[i].tag[5:4]));
      check($sformatf("%s_b%0d_sop", name, i), 128'(obs_q[i].sop), 128'(exp_q[i].sop));
      check($sformatf("%s_b%0d_eop", name, i), 128'(obs_q[i].eop), 128'(exp_q[i].eop));
      check($sformatf("%s_b%0d_err", name, i), 128'(obs_q[i].err), 128'(exp_q[i].tag[0]));
      check($sformatf("%s_b%0d_empty", name, i), 128'(obs_q[i].emp), 128'(exp_q[i].tag[1:0]));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    for (int c = 0; c < NUM_CH; c++) src_q[c].delete();
    obs_q.delete();
    exp_q.delete();
    reset_n = 1'b0;
    tick(1'b1);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n       = 1'b0;
    chan_enable   = 4'hF;
    bus.out_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) drive_ch(c, 1'b0, 8'h00, 1'b0, 1'b0);

    // Two ch0 / ch2 three-beat packets, one row per cycle.
    tbl[0] = mkv(4'b0101, 4'b0101, 4'b0000, 16'h0000, 4'b0000, 0, 0, 8'h00, 0, 0);
    tbl[1] = mkv(4'b0101, 4'b0101, 4'b0000, 16'h0000, 4'b0001, 1, 0, 8'h00, 0, 0);
    tbl[2] = mkv(4'b0101, 4'b0100, 4'b0000, 16'h0001, 4'b0001, 1, 1, 8'h00, 1, 0);
    tbl[3] = mkv(4'b0101, 4'b0100, 4'b0001, 16'h0002, 4'b0001, 1, 1, 8'h01, 0, 0);
    tbl[4] = mkv(4'b0100, 4'b0100, 4'b0000, 16'h0000, 4'b0000, 0, 1, 8'h02, 0, 1);
    tbl[5] = mkv(4'b0100, 4'b0100, 4'b0000, 16'h0000, 4'b0100, 1, 0, 8'h00, 0, 0);
    tbl[6] = mkv(4'b0100, 4'b0000, 4'b0000, 16'h0100, 4'b0100, 1, 1, 8'h20, 1, 0);
    tbl[7] = mkv(4'b0100, 4'b0000, 4'b0100, 16'h0200, 4'b0100, 1, 1, 8'h21, 0, 0);
    tbl[8] = mkv(4'b0000, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 0, 1, 8'h22, 0, 1);
    tbl[9] = mkv(4'b0000, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 0, 0, 8'h00, 0, 0);

    @(negedge clk);
    tick(1'b1);
    tick(1'b1);
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready), 128'(0));
    check("rst_out_data", bus.out_data, 128'(0));
    check("rst_out_channel", 128'(bus.out_channel), 128'(0));
    check("rst_out_sop_eop", 128'({bus.out_startofpacket, bus.out_endofpacket}), 128'(0));
    check("rst_pkt_count", 128'(pkt_count), 128'(0));
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      bus.out_ready = 1'b1;
      for (int c = 0; c < NUM_CH; c++)
        drive_ch(c, tbl[i].vld[c], {4'(c), tbl[i].beat[c*4 +: 4]}, tbl[i].sop[c], tbl[i].eop[c]);
      #1;
      check($sformatf("t1_v%0d_in_ready", i), 128'(bus.in_ready), 128'(tbl[i].x_rdy));
      check($sformatf("t1_v%0d_busy", i), 128'(busy), 128'(tbl[i].x_busy));
      check($sformatf("t1_v%0d_out_valid", i), 128'(bus.out_valid), 128'(tbl[i].x_ov));
      if (tbl[i].x_ov) begin
        check($sformatf("t1_v%0d_data", i), bus.out_data, {16{tbl[i].x_tag}});
        check($sformatf("t1_v%0d_ch", i), 128'(bus.out_channel), 128'(tbl[i].x_tag[5:4]));
        check($sformatf("t1_v%0d_sop", i), 128'(bus.out_startofpacket), 128'(tbl[i].x_sop));
        check($sformatf("t1_v%0d_eop", i), 128'(bus.out_endofpacket), 128'(tbl[i].x_eop));
        check($sformatf("t1_v%0d_err", i), 128'(bus.out_error), 128'(tbl[i].x_tag[0]));
        check($sformatf("t1_v%0d_empty", i), 128'(bus.out_empty), 128'(tbl[i].x_tag[1:0]));
      end
      @(posedge clk);
      @(negedge clk);
    end

    // Rotation: every channel always has a single-beat packet waiting.
    do_reset();
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < NUM_CH; c++) begin
        add_pkt(c, 1, k, 1'b0);
        add_pkt(c, 1, k, 1'b1);
      end
    drain("t2");
    compare_obs("t2");

    // Backpressure on the second beat of a ch1 packet.
    do_reset();
    add_pkt(1, 4, 0, 1'b0);
    n = 0;
    while (!(bus.out_valid && bus.out_data[7:0] == 8'h11) && n < 50) begin
      tick(1'b1);
      n++;
    end
    check("t3_reach_beat2", 128'(n < 50), 128'(1));
    for (int s = 0; s < 3; s++) begin
      bus.out_ready = 1'b0;
      #1;
      check($sformatf("t3_stall%0d_valid", s), 128'(bus.out_valid), 128'(1));
      check($sformatf("t3_stall%0d_data", s), bus.out_data, {16{8'h11}});
      check($sformatf("t3_stall%0d_in_ready", s), 128'(bus.in_ready), 128'(0));
      tick(1'b0);
    end
    drain("t3");
    add_pkt(1, 4, 0, 1'b1);
    compare_obs("t3");

    // ch1 disabled never wins; ch3 still served.
    do_reset();
    chan_enable = 4'b1101;
    add_pkt(1, 2, 0, 1'b0);
    add_pkt(3, 1, 0, 1'b0);
    for (int k = 0; k < 30; k++) tick(1'b1);
    add_pkt(3, 1, 0, 1'b1);
    compare_obs("t4a");
    check("t4a_ch1_pending", 128'(src_q[1].size()), 128'(2));

    // Disabling the granted channel mid-packet lets the packet finish.
    for (int c = 0; c < NUM_CH; c++) src_q[c].delete();
    chan_enable = 4'hF;
    add_pkt(0, 5, 0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick(1'b1);
      n++;
    end
    check("t4b_reach_xfer", 128'(n < 50), 128'(1));
    chan_enable = 4'b1110;
    drain("t4b");
    add_pkt(0, 5, 0, 1'b1);
    compare_obs("t4b");
    check("t4b_idle_after", 128'(busy), 128'(0));

    // Reset during beat 2 of a 5-beat ch2 packet.
    chan_enable = 4'hF;
    do_reset();
    add_pkt(2, 5, 0, 1'b0);
    n = 0;
    while (!(bus.out_valid && bus.out_data[7:0] == 8'h21) && n < 50) begin
      tick(1'b1);
      n++;
    end
    check("t5_reach_beat2", 128'(n < 50), 128'(1));
    reset_n = 1'b0;
    tick(1'b1);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("t5_out_valid", 128'(bus.out_valid), 128'(0));
    check("t5_busy", 128'(busy), 128'(0));
    check("t5_in_ready", 128'(bus.in_ready), 128'(0));
    check("t5_pkt_count", 128'(pkt_count), 128'(0));
    for (int c = 0; c < NUM_CH; c++) src_q[c].delete();
    obs_q.delete();
    add_pkt(3, 1, 0, 1'b0);
    add_pkt(0, 1, 0, 1'b0);
    drain("t5");
    add_pkt(0, 1, 0, 1'b1);
    add_pkt(3, 1, 0, 1'b1);
    compare_obs("t5");

    // Completed-packet counters on ch3 (CNT_W=4 here, so 17 wraps to 1).
    do_reset();
    for (int k = 0; k < 5; k++) add_pkt(3, 2, k, 1'b0);
    drain("t6a");
`ifdef SONIC_VC_TX_ARB_PKT_COUNT_EN
    check("t6_cnt3_after5", 128'(pkt_count[3*CNT_W +: CNT_W]), 128'(5));
    check("t6_cnt_others", 128'(pkt_count[3*CNT_W-1:0]), 128'(0));
`else
    check("t6_cnt_tied_zero", 128'(pkt_count), 128'(0));
`endif
    for (int k = 0; k < 12; k++) add_pkt(3, 1, k, 1'b0);
    drain("t6b");
`ifdef SONIC_VC_TX_ARB_PKT_COUNT_EN
    check("t6_cnt3_after17", 128'(pkt_count[3*CNT_W +: CNT_W]), 128'(1));
    check("t6_cnt_others_17", 128'(pkt_count[3*CNT_W-1:0]), 128'(0));
`else
    check("t6_cnt_tied_zero_17", 128'(pkt_count), 128'(0));
`endif
    obs_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sonic_vc_tx_arbiter.md
Name: sonic_vc_tx_arbiter

Overview:
Packet-aware round-robin arbiter that merges NUM_CH virtual-channel Avalon-ST sources into the single 128-bit stream feeding the VC TX FIFO timing adapter. A grant is held from the start-of-packet beat to the end-of-packet beat, so packets are never interleaved. One registered output stage supports out_ready backpressure from the adapter. Software can enable or disable each channel through chan_enable.

Parameters:
NUM_CH, 4, number of requesting virtual channels (2..8)
DATA_W, 128, data bus width
EMPTY_W, 2, width of the empty field
CNT_W, 32, packet counter width (used only with the optional feature)

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
chan_enable  input  NUM_CH  per-channel arbitration enable
in_valid  input  NUM_CH  per-channel valid
in_ready  output  NUM_CH  per-channel ready
in_data  input  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
in_error  input  NUM_CH  per-channel error
in_startofpacket  input  NUM_CH  per-channel SOP
in_endofpacket  input  NUM_CH  per-channel EOP
in_empty  input  NUM_CH*EMPTY_W  per-channel empty
out_ready  input  1  downstream ready
out_valid  output  1  merged valid
out_data  output  DATA_W  merged data
out_error  output  1  merged error
out_startofpacket  output  1  merged SOP
out_endofpacket  output  1  merged EOP
out_empty  output  EMPTY_W  merged empty
out_channel  output  clog2(NUM_CH)  source channel of the current out beat
busy  output  1  high while in XFER
pkt_count  output  NUM_CH*CNT_W  per-channel completed-packet counters

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, synchronous and active-low. All registers are updated on the rising edge of clk.
- Reset values: state=IDLE, grant=0, last_grant=NUM_CH-1 (so ch0 wins first), out_valid=0, out_data=0, out_error=0, out_startofpacket=0, out_endofpacket=0, out_empty=0, out_channel=0, busy=0, pkt_count=0. in_ready is all zeros.
- Reset mid-packet: the packet is abandoned with no EOP emitted. out_valid drops on the cycle after reset is sampled.
- Output stage: out_* are registered. It can advance when (!out_valid || out_ready).
- Input ready: in_ready[c] = (state==XFER) && (grant==c) && (!out_valid || out_ready). Combinational and one-hot or zero.
- Beat accept: in_valid[grant] && in_ready[grant]. The accepted beat appears on out_* on the next cycle (latency 1). out_valid holds with stable payload while !out_ready.
- If no beat is accepted while out_ready=1, out_valid clears.
- State IDLE: req = in_valid & chan_enable & in_startofpacket. Round-robin pick of the first set req starting at last_grant+1, wrapping modulo NUM_CH. If any request is set, load grant and move to XFER next cycle; otherwise stay in IDLE.
- State XFER: forward beats from grant. On an accepted beat with in_endofpacket=1: last_grant<=grant, move to IDLE. Result: minimum one-cycle gap between packets.
- Single-beat packets (SOP and EOP on the same beat) are legal.
- A valid beat without SOP in IDLE is not granted; the channel stalls, since in_ready stays 0.
- Clearing chan_enable[grant] during XFER does not abort the packet. It only affects future arbitration.
- A new SOP on the granted channel before EOP is forwarded unchanged; the arbiter does not check it.
- out_channel is registered with the payload. busy = (state==XFER).

Optional Feature:
- Macro: SONIC_VC_TX_ARB_PKT_COUNT_EN.
- Defined: pkt_count[c] increments by 1 on every accepted EOP beat from channel c. It wraps from 2^CNT_W-1 to 0 and clears on reset.
- Undefined: pkt_count is tied to 0 and no counter registers are synthesized.

Test Plan:
- Reset, then ch0 and ch2 each present a 3-beat packet with all channels enabled and out_ready=1 -> ch0 packet out first (SOP at cycle 2 after request), then after one gap cycle ch2's 3 beats follow with out_channel=2. No interleave.
- All 4 channels continuously request 1-beat packets -> grant order 0,1,2,3,0,...; each granted exactly once per 4 packets.
- ch1 sends a 4-beat packet; out_ready is held low for 3 cycles on beat 2 -> out_data holds beat 2 stable, in_ready[1]=0 during the stall, no beat lost or duplicated.
- chan_enable=4'b1101 with ch1 requesting -> ch1 never granted. Clearing chan_enable[0] mid-packet on ch0 -> ch0 packet completes through EOP.
- reset_n low for 1 cycle during beat 2 of a 5-beat packet -> next cycle out_valid=0, state IDLE, last_grant=NUM_CH-1, pkt_count=0.
- With SONIC_VC_TX_ARB_PKT_COUNT_EN defined: 5 packets on ch3 -> pkt_count[3]=5, others 0. With CNT_W=4 and 17 packets -> pkt_count[3]=1.
